huffman_bit_packer: RTL and testbench

- Downstream stage of the Huffman encoder.
- Loads the (symbol, length, code) table that the encoder emits, then takes the raw symbol stream, replaces each symbol with its code and packs the variable-length codes MSB-first into 8-bit output words.
- Output goes to the compressed-file writer.
- Ends each stream with a zero-padded final byte and reports the total payload bit count.

---
 rtl/huffman_bit_packer.sv | 169 ++++++++++++++++
 tb/tb_huffman_bit_packer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_bit_packer.sv
// huffman_bit_packer
//   Downstream stage of the Huffman encoder. Holds the (symbol -> length, code)
//   table written by the encoder, then maps a raw symbol stream to codes and
//   packs them MSB-first into bytes for the compressed-file writer. A flush
//   ends the stream: remaining full bytes drain, a final partial byte is
//   zero-padded, and done pulses once the last byte is taken.
//
// Ports
//   clock, rst          rising-edge clock, asynchronous active-low reset
//   tbl_wr_en/_symbol/  table write (honoured only while idle)
//   _length/_code
//   start, flush        1-cycle stream begin / end pulses
//   sym_valid/_data,    symbol input handshake
//   sym_ready
//   byte_valid/_data,   packed byte output handshake, first code bit at bit 7
//   byte_ready
//   bit_count           code bits packed in this stream (padding excluded)
//   done                1-cycle pulse after the last byte is accepted
//   error               sticky: a symbol hit an unused / over-long table entry
module huffman_bit_packer #(
  parameter int bit_width  = 7,
  parameter int max_symbol = 255,
  parameter int max_length = 8
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               tbl_wr_en,
  input  logic [bit_width:0] tbl_symbol,
  input  logic [3:0]         tbl_length,
  input  logic [bit_width:0] tbl_code,
  input  logic               start,
  input  logic               sym_valid,
  input  logic [bit_width:0] sym_data,
  output logic               sym_ready,
  input  logic               flush,
  output logic               byte_valid,
  output logic [7:0]         byte_data,
  input  logic               byte_ready,
  output logic [15:0]        bit_count,
  output logic               done,
  output logic               error
);

  localparam int  TBL_N    = max_symbol + 1;
  localparam bit  FULL_TBL = (max_symbol >= (1 << (bit_width + 1)) - 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, PAD, DONE} state_t;

  typedef struct packed {
    logic [3:0]         len;
    logic [bit_width:0] code;
  } entry_t;

  state_t      state, state_nxt;
  entry_t      tbl [TBL_N];
  entry_t      ent;
  logic        rd_ok, wr_ok;
  logic [15:0] acc, acc_nxt;
  logic [4:0]  count, count_nxt;
  logic        len_ok, sym_fire, append, pop;
  logic [15:0] code_ext, code_mask, hi_sh, pad_sh;

  // Symbols outside the table range behave like an unused entry.
  generate
    if (FULL_TBL) begin : g_full
      assign rd_ok = 1'b1;
      assign wr_ok = 1'b1;
    end else begin : g_part
      assign rd_ok = (int'(sym_data)   <= max_symbol);
      assign wr_ok = (int'(tbl_symbol) <= max_symbol);
    end
  endgenerate

  // Table is deliberately outside reset so it survives a mid-stream abort.
  always_ff @(posedge clock) begin
    if (state == IDLE && tbl_wr_en && wr_ok)
      tbl[tbl_symbol] <= '{len: tbl_length, code: tbl_code};
  end

  assign ent       = rd_ok ? tbl[sym_data] : '0;
  assign len_ok    = (ent.len != 4'd0) && (int'(ent.len) <= max_length);
  assign code_ext  = 16'(ent.code);
  assign code_mask = (16'd1 << ent.len) - 16'd1;

  // FSM: next state and handshake outputs, all from registered state/count.
  always_comb begin
    state_nxt  = state;
    sym_ready  = 1'b0;
    byte_valid = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        sym_ready  = (count <= 5'd8);
        byte_valid = (count >= 5'd8);
        if (flush) state_nxt = DRAIN;
      end
      DRAIN: begin
        byte_valid = (count >= 5'd8);
        if (count == 5'd0)     state_nxt = DONE;
        else if (count < 5'd8) state_nxt = PAD;
      end
      PAD: begin
        byte_valid = 1'b1;
        if (byte_ready) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sym_fire = sym_ready & sym_valid;
  assign append   = sym_fire & len_ok;
  assign pop      = byte_valid & byte_ready & (state != PAD);

  // Valid bits sit at acc[count-1:0]; the oldest bit is the MSB of that field.
  // Bits above count are stale and never observed. Since sym_ready needs
  // count <= 8, count + len never exceeds 16 and nothing valid is shifted out.
  always_comb begin
    acc_nxt   = acc;
    count_nxt = count;
    if (pop) count_nxt = count - 5'd8;
    if (append) begin
      acc_nxt   = (acc << ent.len) | (code_ext & code_mask);
      count_nxt = count_nxt + {1'b0, ent.len};
    end
    if (state == PAD && byte_ready) count_nxt = '0;
  end

  // Full byte is the top 8 valid bits; the pad byte left-aligns the 1..7
  // remaining bits. A same-cycle append in RUN shifts acc and count together,
  // so the presented byte stays put until it is taken.
  assign hi_sh  = acc >> (count - 5'd8);
  assign pad_sh = acc << (5'd8 - count);

  always_comb begin
    byte_data = '0;
    if (state == PAD)    byte_data = pad_sh[7:0];
    else if (byte_valid) byte_data = hi_sh[7:0];
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      count     <= '0;
      bit_count <= '0;
      error     <= 1'b0;
    end else if (state == IDLE && start) begin
      acc       <= '0;
      count     <= '0;
      bit_count <= '0;
      error     <= 1'b0;
    end else begin
      acc   <= acc_nxt;
      count <= count_nxt;
      if (append)              bit_count <= bit_count + 16'(ent.len);
      if (sym_fire && !len_ok) error     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Scoreboard bench for huffman_bit_packer. The reference keeps the stream as a
// plain queue of code bits; accepted symbols append their bits, every 8 bits
// become an expected byte, flush pads the tail. A monitor pops and compares
// each byte handshake independently of the stimulus.
module tb_huffman_bit_packer;

  logic        clock = 1'b0;
  logic        rst   = 1'b0;
  logic        tbl_wr_en = 1'b0;
  logic [7:0]  tbl_symbol = '0;
  logic [3:0]  tbl_length = '0;
  logic [7:0]  tbl_code = '0;
  logic        start = 1'b0;
  logic        sym_valid = 1'b0;
  logic [7:0]  sym_data = '0;
  logic        sym_ready;
  logic        flush = 1'b0;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready = 1'b0;
  logic [15:0] bit_count;
  logic        done;
  logic        error;

  huffman_bit_packer #(.bit_width(7), .max_symbol(255), .max_length(8)) dut (
    .clock(clock), .rst(rst),
    .tbl_wr_en(tbl_wr_en), .tbl_symbol(tbl_symbol), .tbl_length(tbl_length),
    .tbl_code(tbl_code), .start(start), .sym_valid(sym_valid),
    .sym_data(sym_data), .sym_ready(sym_ready), .flush(flush),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .bit_count(bit_count), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int         chk = 0, errs = 0;
  int         mlen [256];
  int         mcode[256];
  bit         mbits[$];
  logic [7:0] exp_q[$];
  int         exp_bits = 0;
  bit         exp_err = 1'b0;
  int         done_cnt = 0, pop_cnt = 0;
  int         rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic m_accept(int s);
    logic [7:0] b;
    if (mlen[s] >= 1 && mlen[s] <= 8) begin
      for (int i = mlen[s] - 1; i >= 0; i--) mbits.push_back(mcode[s][i]);
      exp_bits += mlen[s];
      while (mbits.size() >= 8) begin
        b = '0;
        for (int i = 0; i < 8; i++) b = {b[6:0], mbits.pop_front()};
        exp_q.push_back(b);
      end
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic m_flush();
    logic [7:0] b;
    if (mbits.size() > 0) begin
      b = '0;
      for (int i = 0; i < 8; i++)
        b = {b[6:0], (mbits.size() > 0) ? mbits.pop_front() : 1'b0};
      exp_q.push_back(b);
    end
  endtask

  // ---------------- monitor ----------------
  logic [7:0] hold_data = '0;
  bit         hold = 1'b0;

  always @(negedge clock) begin
    if (!rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 32'(byte_valid), 32'd1);
        check("hold_data", 32'(byte_data), 32'(hold_data));
      end
      if (byte_valid && byte_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          chk++; errs++;
          $display("FAIL unexpected_byte act=%0h exp=none", byte_data);
        end else begin
          check("byte", 32'(byte_data), 32'(exp_q.pop_front()));
        end
      end
      hold      = byte_valid && !byte_ready;
      hold_data = byte_data;
      if (done) done_cnt++;
    end
  end

  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0:       byte_ready = 1'($urandom_range(0, 1));
      1:       byte_ready = 1'b1;
      default: byte_ready = 1'b0;
    endcase
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic tbl_write(int s, int len, int code, bit honoured);
    tbl_wr_en = 1'b1; tbl_symbol = 8'(s); tbl_length = 4'(len); tbl_code = 8'(code);
    cyc();
    tbl_wr_en = 1'b0;
    if (honoured) begin mlen[s] = len; mcode[s] = code; end
  endtask

  task automatic start_stream();
    start = 1'b1;
    cyc();
    start = 1'b0;
    mbits.delete(); exp_bits = 0; exp_err = 1'b0;
  endtask

  task automatic send(int s, bit with_flush);
    bit ok = 1'b0;
    int n = 0;
    sym_valid = 1'b1; sym_data = 8'(s);
    while (!ok && n < 500) begin
      @(negedge clock);
      ok = sym_ready;
      if (ok && with_flush) flush = 1'b1;
      @(posedge clock); #1;
      n++;
    end
    sym_valid = 1'b0; flush = 1'b0;
    if (!ok) begin
      chk++; errs++;
      $display("FAIL sym_accept_timeout act=0 exp=1");
    end else begin
      m_accept(s);
      if (with_flush) m_flush();
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    m_flush();
  endtask

  task automatic end_stream();
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 2000) begin cyc(); n++; end
    cyc(3);
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("missing_bytes", 32'(exp_q.size()), 32'd0);
    check("bit_count", 32'(bit_count), 32'(exp_bits[15:0]));
    check("error", 32'(error), 32'(exp_err));
    check("idle_outputs", {30'd0, sym_ready, byte_valid}, 32'd0);
  endtask

  int p0;

  initial begin
    foreach (mlen[i]) begin mlen[i] = 0; mcode[i] = 0; end
    cyc(3);
    check("rst_sym_ready", 32'(sym_ready), 32'd0);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_byte_data", 32'(byte_data), 32'd0);
    check("rst_bit_count", 32'(bit_count), 32'd0);
    rst = 1'b1;
    cyc(2);

    // Basic stream; a table write while running must be ignored.
    tbl_write(8'h41, 2, 2, 1'b1);
    tbl_write(8'h42, 3, 3, 1'b1);
    tbl_write(8'h43, 1, 0, 1'b1);
    start_stream();
    tbl_write(8'h43, 5, 8'h1F, 1'b0);
    send(8'h41, 0); send(8'h42, 0); send(8'h43, 0); send(8'h41, 0); send(8'h42, 0);
    do_flush();
    end_stream();
    check("t1_bit_count", 32'(bit_count), 32'd11);

    // Eight 8-bit codes with a 5-cycle downstream stall mid-stream.
    for (int i = 0; i < 8; i++) tbl_write(8'h10 + i, 8, i + 1, 1'b1);
    start_stream();
    p0 = pop_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) send(8'h10 + i, 0);
      end
      begin
        cyc(4);
        rdy_mode = 2;
        cyc(5);
        check("stall_sym_ready", 32'(sym_ready), 32'd0);
        check("stall_byte_valid", 32'(byte_valid), 32'd1);
        rdy_mode = 1;
      end
    join
    do_flush();
    end_stream();
    check("t2_byte_count", 32'(pop_cnt - p0), 32'd8);

    // Unused table entry: dropped, error sticky until next start.
    tbl_write(8'h44, 0, 0, 1'b1);
    start_stream();
    send(8'h41, 0); send(8'h44, 0); send(8'h42, 0); send(8'h43, 0);
    do_flush();
    end_stream();
    check("t3_error_set", 32'(error), 32'd1);

    // Empty stream; also confirms start clears error.
    start_stream();
    check("t5_error_cleared", 32'(error), 32'd0);
    p0 = pop_cnt;
    do_flush();
    end_stream();
    check("t5_no_bytes", 32'(pop_cnt - p0), 32'd0);
    check("t5_bit_count", 32'(bit_count), 32'd0);

    // Pop + append in the same cycle, and a symbol accepted with flush.
    start_stream();
    send(8'h42, 0); send(8'h42, 0); send(8'h41, 0); send(8'h43, 0);
    send(8'h42, 1);
    end_stream();
    check("t4_bit_count", 32'(bit_count), 32'd12);

    // Reset mid-stream with 5 bits pending, then replay the first stream.
    start_stream();
    send(8'h41, 0); send(8'h42, 0);
    cyc();
    rst = 1'b0;
    #1;
    check("mid_rst_outputs",
          {bit_count, byte_data, 4'd0, sym_ready, byte_valid, done, error}, 32'd0);
    exp_q.delete(); mbits.delete();
    cyc();
    rst = 1'b1;
    cyc(2);
    start_stream();
    send(8'h41, 0); send(8'h42, 0); send(8'h43, 0); send(8'h41, 0); send(8'h42, 0);
    do_flush();
    end_stream();

    // Randomized streams with random backpressure.
    for (int s = 0; s < 15; s++)
      tbl_write(s, $urandom_range(1, 8), $urandom_range(0, 255), 1'b1);
    tbl_write(15, 9, 8'h55, 1'b1);
    rdy_mode = 0;
    for (int k = 0; k < 5; k++) begin
      int nsym = $urandom_range(10, 40);
      start_stream();
      for (int j = 0; j < nsym; j++)
        send((k == 2) ? $urandom_range(0, 15) : $urandom_range(0, 14),
             (j == nsym - 1) && k[0]);
      if (!k[0]) do_flush();
      end_stream();
    end
    rdy_mode = 1;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule
